// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB bus between the requester bridge and the register-bank completer.
interface apb_slave_regfile_if #(
  parameter int WIDTH = 16
);
  logic             pselect;
  logic             penable;
  logic             pwrite;
  logic [WIDTH-1:0] paddr;
  logic [WIDTH-1:0] pwdata;
  logic             pready;
  logic [WIDTH-1:0] prdata;
  logic             pslverr;
  modport master(output pselect, penable, pwrite, paddr, pwdata, input pready, prdata, pslverr);
  modport slave(input pselect, penable, pwrite, paddr, pwdata, output pready, prdata, pslverr);
endinterface

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with DEPTH word registers, programmable wait states and read-only ID at index 0.
// Optional APB_SLV_WAIT_REG_EN: register DEPTH-1 bits[3:0] supply the per-transfer wait count.
module apb_slave_regfile #(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 8,
  parameter int               WAIT_STATES = 1,
  parameter logic [WIDTH-1:0] ID_VALUE    = 16'hA5B0
) (
  input logic                pclk,
  input logic                preset_n,
  apb_slave_regfile_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE = 3'b001, WAIT = 3'b010, DONE = 3'b100} state_t;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] prdata_q, prdata_d;
  logic             write_q, write_d;
  logic             pready_q, pready_d;
  logic             pslverr_q, pslverr_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] acc_addr;
  logic [AW-1:0]    acc_idx;
  logic             acc_write, acc_err, finish, commit;
  logic [3:0]       wait_load;
`ifdef APB_SLV_WAIT_REG_EN
  assign wait_load = regs_q[DEPTH-1][3:0];
`else
  assign wait_load = 4'(WAIT_STATES);
`endif
  // Zero-wait transfers finish on the setup edge, before the bus fields are latched.
  always_comb begin
    acc_addr  = state_q == IDLE ? bus.paddr : addr_q;
    acc_write = state_q == IDLE ? bus.pwrite : write_q;
    acc_idx   = acc_addr[AW-1:0];
    acc_err   = acc_addr >= WIDTH'(DEPTH) || (acc_write && acc_idx == '0);
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    finish    = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: if (bus.pselect && !bus.penable) begin
        addr_d  = bus.paddr;
        wdata_d = bus.pwdata;
        write_d = bus.pwrite;
        cnt_d   = wait_load;
        finish  = wait_load == 4'd0;
        state_d = finish ? DONE : WAIT;
      end
      WAIT: if (!bus.pselect) state_d = IDLE;
      else if (bus.penable) begin
        finish  = cnt_q == 4'd1;
        cnt_d   = cnt_q - 4'd1;
        state_d = finish ? DONE : WAIT;
      end
      DONE: begin
        commit  = bus.pselect && write_q && !pslverr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (finish) begin
      pready_d  = 1'b1;
      pslverr_d = acc_err;
      prdata_d  = (acc_write || acc_err) ? '0 : acc_idx == '0 ? ID_VALUE : regs_q[acc_idx];
    end
  end
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
`ifdef APB_SLV_WAIT_REG_EN
      regs_q[DEPTH-1] <= WIDTH'(WAIT_STATES);
`endif
    end else if (commit) regs_q[addr_q[AW-1:0]] <= wdata_q;
  assign bus.pready  = pready_q;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: scoreboard bench driving a zero-wait (lane 0) and a one-wait (lane 1) instance.
module tb_apb_slave_regfile;
  typedef struct {
    logic [15:0] data;
    logic        err;
    logic        rd;
    int          lat;
  } exp_t;
  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q [2][$];
  logic [15:0] mdl [2][8];
  int acc [2];
  apb_slave_regfile_if #(.WIDTH(16)) b0 ();
  apb_slave_regfile_if #(.WIDTH(16)) b1 ();
  apb_slave_regfile #(.WIDTH(16), .DEPTH(8), .WAIT_STATES(0), .ID_VALUE(16'hA5B0)) u0 (
    .pclk(pclk), .preset_n(preset_n), .bus(b0));
  apb_slave_regfile #(.WIDTH(16), .DEPTH(8), .WAIT_STATES(1), .ID_VALUE(16'hA5B0)) u1 (
    .pclk(pclk), .preset_n(preset_n), .bus(b1));
  always #5 pclk = ~pclk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask
  function automatic logic rdy(input int l);
    return l == 0 ? b0.pready : b1.pready;
  endfunction
  function automatic logic [15:0] rdat(input int l);
    return l == 0 ? b0.prdata : b1.prdata;
  endfunction
  function automatic logic rerr(input int l);
    return l == 0 ? b0.pslverr : b1.pslverr;
  endfunction
  function automatic logic sel(input int l);
    return l == 0 ? b0.pselect : b1.pselect;
  endfunction
  function automatic logic en(input int l);
    return l == 0 ? b0.penable : b1.penable;
  endfunction
  task automatic drv(input int l, input logic s, input logic e, input logic w,
                     input logic [15:0] a, input logic [15:0] d);
    if (l == 0) begin
      b0.pselect = s; b0.penable = e; b0.pwrite = w; b0.paddr = a; b0.pwdata = d;
    end else begin
      b1.pselect = s; b1.penable = e; b1.pwrite = w; b1.paddr = a; b1.pwdata = d;
    end
  endtask
  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    repeat (n) begin @(posedge pclk); #1; end
  endtask
  task automatic clear_model();
    for (int l = 0; l < 2; l++) for (int i = 0; i < 8; i++) mdl[l][i] = '0;
  endtask
  // Reference: addresses beyond DEPTH or writes to the ID word fail; only good writes update storage.
  function automatic exp_t predict(input int l, input logic w, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    int i;
    i = int'(a % 16'd8);
    e.lat  = l == 0 ? 1 : 2;
    e.err  = (a >= 16'd8) || (w && i == 0);
    e.rd   = !w;
    e.data = (w || e.err) ? 16'h0 : (i == 0 ? 16'hA5B0 : mdl[l][i]);
    if (w && !e.err) mdl[l][i] = d;
    return e;
  endfunction
  // Leaves the bus in the completion cycle's aftermath; a following call starts its setup back-to-back.
  task automatic xfer(input int l, input logic w, input logic [15:0] a, input logic [15:0] d);
    int n;
    q[l].push_back(predict(l, w, a, d));
    drv(l, 1, 0, w, a, d);
    @(posedge pclk); #1;
    drv(l, 1, 1, w, a, d);
    n = 0;
    while (!rdy(l) && n < 40) begin @(posedge pclk); #1; n++; end
    if (n >= 40) chk("pready_timeout", 0, 1);
    @(posedge pclk); #1;
    drv(l, 0, 0, 0, 0, 0);
  endtask
  always @(negedge pclk) begin
    exp_t e;
    for (int l = 0; l < 2; l++) begin
      if (!en(l)) acc[l] = 0;
      else if (sel(l)) acc[l]++;
      if (rdy(l) === 1'b1) begin
        if (q[l].size() == 0) chk($sformatf("unexpected_pready_lane%0d", l), 1, 0);
        else begin
          e = q[l].pop_front();
          chk($sformatf("latency_lane%0d", l), acc[l], e.lat);
          chk($sformatf("pslverr_lane%0d", l), {31'd0, rerr(l)}, {31'd0, e.err});
          if (e.rd) chk($sformatf("prdata_lane%0d", l), {16'd0, rdat(l)}, {16'd0, e.data});
        end
        acc[l] = 0;
      end else chk($sformatf("idle_outputs_lane%0d", l), {15'd0, rerr(l), rdat(l)}, 32'd0);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int l;
    logic w;
    logic [15:0] a;
    logic [15:0] d;
    acc[0] = 0;
    acc[1] = 0;
    clear_model();
    idle(0);
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_pready", {31'd0, b1.pready}, 0);
    chk("reset_prdata", {16'd0, b1.prdata}, 0);
    chk("reset_pslverr", {31'd0, b1.pslverr}, 0);
    preset_n = 1'b1;
    idle(1);
    xfer(1, 0, 16'd0, 16'h0);
    xfer(1, 1, 16'd3, 16'h1234);
    xfer(1, 0, 16'd3, 16'h0);
    for (int i = 1; i < 8; i++) xfer(1, 0, 16'(i), 16'h0);
    xfer(1, 1, 16'd0, 16'hFFFF);
    xfer(1, 0, 16'd0, 16'h0);
    xfer(1, 0, 16'd8, 16'h0);
    xfer(1, 1, 16'd8, 16'hBEEF);
    for (int i = 0; i < 8; i++) xfer(1, 0, 16'(i), 16'h0);
    xfer(0, 1, 16'd1, 16'hAAAA);
    xfer(0, 1, 16'd2, 16'h5A5A);
    xfer(0, 0, 16'd1, 16'h0);
    xfer(0, 0, 16'd2, 16'h0);
    idle(1);
    // Abort in WAIT: deselect before the first access edge, write must be dropped.
    drv(1, 1, 0, 1, 16'd5, 16'hDEAD);
    @(posedge pclk); #1;
    drv(1, 0, 0, 0, 0, 0);
    idle(2);
    xfer(1, 0, 16'd5, 16'h0);
    // Protocol violation: access strobe without setup is ignored.
    drv(1, 1, 1, 1, 16'd6, 16'h6666);
    @(posedge pclk); #1;
    idle(2);
    xfer(1, 0, 16'd6, 16'h0);
    // Reset asserted during the wait of a write.
    drv(1, 1, 0, 1, 16'd4, 16'h5555);
    @(posedge pclk); #1;
    drv(1, 1, 1, 1, 16'd4, 16'h5555);
    #2 preset_n = 1'b0;
    #1;
    chk("midreset_pready", {31'd0, b1.pready}, 0);
    clear_model();
    idle(1);
    preset_n = 1'b1;
    idle(1);
    xfer(1, 0, 16'd4, 16'h0);
    xfer(1, 0, 16'd3, 16'h0);
    for (int k = 0; k < 80; k++) begin
      l = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 11));
      d = 16'($urandom);
      xfer(l, w, a, d);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 2)));
    end
    idle(4);
    chk("scoreboard_drained_lane0", q[0].size(), 0);
    chk("scoreboard_drained_lane1", q[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
